// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs a decoded-field bundle into a 32-bit machine word,
// tags it with a sequential instruction-memory address and rejects/counts illegal bundles.
module instr_encoder #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_count
);

  typedef enum logic [3:0] {
    CLS_OP     = 4'd0,
    CLS_OPIMM  = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8
  } cls_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic              r_valid;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic [7:0]        r_err_count;

  logic [31:0] w_instr;
  logic        w_illegal;
  logic        w_accept;
  logic        w_i_ok, w_b_ok, w_j_ok, w_u_ok;
  logic        w_shift;
  logic [6:0]  w_f7;

  // Immediate range checks: value must be the sign-extension of the field's top bit.
  assign w_i_ok  = (in_imm[31:11] == {21{in_imm[11]}});
  assign w_b_ok  = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
  assign w_j_ok  = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
  assign w_u_ok  = (in_imm[11:0] == 12'd0);
  assign w_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
  assign w_f7    = in_alt ? 7'b0100000 : 7'b0000000;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_instr   = '0;
    w_illegal = 1'b0;
    case (in_class)
      CLS_OP: begin
        w_instr   = {w_f7, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP};
        w_illegal = in_alt && !((in_funct3 == 3'b000) || (in_funct3 == 3'b101));
      end
      CLS_OPIMM: begin
        if (w_shift) begin
          w_instr   = {w_f7, in_imm[4:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
          w_illegal = (in_imm[31:5] != '0) || (in_alt && (in_funct3 != 3'b101));
        end else begin
          w_instr   = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
          w_illegal = !w_i_ok || in_alt;
        end
      end
      CLS_LOAD: begin
        w_instr   = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
        w_illegal = !w_i_ok || in_alt || (in_funct3 == 3'b011) || (in_funct3[2:1] == 2'b11);
      end
      CLS_STORE: begin
        w_instr   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
        w_illegal = !w_i_ok || in_alt || (in_funct3 >= 3'b011);
      end
      CLS_BRANCH: begin
        w_instr   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], OPC_BRANCH};
        w_illegal = !w_b_ok || in_alt || (in_funct3[2:1] == 2'b01);
      end
      CLS_JAL: begin
        w_instr   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
        w_illegal = !w_j_ok || in_alt;
      end
      CLS_JALR: begin
        w_instr   = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
        w_illegal = !w_i_ok || in_alt || (in_funct3 != 3'b000);
      end
      CLS_LUI: begin
        w_instr   = {in_imm[31:12], in_rd, OPC_LUI};
        w_illegal = !w_u_ok || in_alt;
      end
      CLS_AUIPC: begin
        w_instr   = {in_imm[31:12], in_rd, OPC_AUIPC};
        w_illegal = !w_u_ok || in_alt;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Single holding register; back-pressure passes straight through when it drains.
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    if (rst || start) begin
      r_valid     <= 1'b0;
      r_instr     <= '0;
      r_addr      <= '0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err <= w_accept && w_illegal;
      if (w_accept && w_illegal && (r_err_count != 8'hFF))
        r_err_count <= r_err_count + 8'd1;
      if (r_valid && out_ready)
        r_addr <= r_addr + 1'b1;
      if (w_accept && !w_illegal) begin
        r_valid <= 1'b1;
        r_instr <= w_instr;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_instr = r_instr;
  assign out_addr  = r_addr;
  assign err       = r_err;
  assign err_count = r_err_count;

endmodule
